lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl - single-outstanding load/store unit controller.
//
// Accepts one core request at a time and runs it against a word-wide data
// memory. Loads read the word once and format the selected byte/halfword.
// Word stores write straight through. Byte/halfword stores read the word,
// merge the new lane in and write it back. Misaligned accesses and illegal
// funct3 codes never touch memory and answer with resp_err.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          1=store / 0=load, RISC-V width/sign code
//   req_addr, req_wdata         byte address, right-aligned store data
//   resp_valid/resp_err         one-cycle completion pulse and error flag
//   resp_rdata                  formatted load data (0 for stores/errors)
//   addr, dataW, MemRW          word address, write data, write strobe
//   dataB                       memory read data, same-cycle
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] addr,
    output logic [31:0] dataW,
    output logic        MemRW,
    input  logic [31:0] dataB
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_RMW   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;

    logic        req_legal, req_misal, req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [31:0] wr_word;

    // Decode of the incoming request, used only on the acceptance edge.
    always_comb begin
        if (req_we)
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        else
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err   = !req_legal || req_misal;
    end

    // Load formatting: lane select from the latched address, then extend.
    always_comb begin
        ld_byte = dataB[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dataB[31:16] : dataB[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = dataB;
        endcase
    end

    // Store merge: sub-word stores replace one lane of the word read back.
    always_comb begin
        wr_word = merge_q;
        case (f3_q[1:0])
            2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = 32'd0;
                    if (req_err)                       state_d = S_RESP;
                    else if (!req_we)                  state_d = S_READ;
                    else if (req_funct3[1:0] == 2'b10) state_d = S_WRITE;
                    else                               state_d = S_RMW;
                end
            end
            S_READ: begin
                rdata_d = ld_fmt;
                state_d = S_RESP;
            end
            S_RMW: begin
                merge_d = dataB;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    // All outputs decode from state, so the async reset clears them at once
    // (a WRITE in flight loses its strobe before the next edge).
    logic mem_act;
    assign mem_act    = (state_q == S_READ) || (state_q == S_RMW) || (state_q == S_WRITE);
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign addr       = mem_act ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dataW      = (state_q == S_WRITE) ? wr_word : 32'd0;
    assign MemRW      = (state_q == S_WRITE);

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, addr, dataW, dataB;
    logic        MemRW;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .addr(addr), .dataW(dataW), .MemRW(MemRW), .dataB(dataB)
    );

    always #5 clk = ~clk;

    // Data memory model: 16 words, combinational read, write on rising edge.
    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'd0;
    int          wr_cnt = 0;

    assign dataB = mem[addr[5:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (MemRW) begin
            mem[addr[5:2]] <= dataW;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, init;
        logic        err;
        logic [31:0] rd, fin;
        int          lat, nwr;
    } vec_t;

    // Behavioural reference: byte-level arithmetic straight from the rules.
    function automatic vec_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] word);
        vec_t v;
        int size, sh;
        logic legal;
        logic [31:0] mask, x;
        v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.init = word;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        v.err = !legal || ((size < 8) && (a % size != 0));
        v.rd = 0; v.fin = word; v.nwr = 0; v.lat = 1;
        if (!v.err) begin
            sh   = (size == 4) ? 0 : 8 * int'(a % 4);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
            if (!we) begin
                x = (word >> sh) & mask;
                if (!f3[2] && size < 4 && x[8*size-1]) x = x | ~mask;
                v.rd = x; v.lat = 2;
            end else begin
                v.fin = (word & ~(mask << sh)) | ((wd & mask) << sh);
                v.nwr = 1;
                v.lat = (size == 4) ? 2 : 3;
            end
        end
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[5:2]; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Runs one access end to end and checks every observable result.
    task automatic run(input string nm, input vec_t v);
        int w0, lat, cyc, leak;
        logic got_err;
        logic [31:0] got_rd, seen_addr;
        bit ok;
        preload(v.a, v.init);
        w0 = wr_cnt; lat = 0; leak = 0; seen_addr = 0; got_err = 0; got_rd = 0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.a; req_wdata = v.wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (cyc = 1; cyc <= 8; cyc++) begin
            if (addr != 0) seen_addr = addr;
            if (!MemRW && dataW != 0) leak++;
            if (resp_valid) begin
                lat = cyc; got_err = resp_err; got_rd = resp_rdata;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk({nm, "_err"}, 32'(got_err), 32'(v.err));
        chk({nm, "_rdata"}, got_rd, v.rd);
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_mem"}, mem[v.a[5:2]], v.fin);
        chk({nm, "_nwr"}, wr_cnt - w0, v.nwr);
        chk({nm, "_addr"}, seen_addr, v.err ? 32'd0 : {v.a[31:2], 2'b00});
        chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
        chk({nm, "_dataw_idle"}, leak, 0);
    endtask

    vec_t tbl [13];

    initial begin
        int acc [$];
        int rsp [$];
        int w0;
        bit ok;
        vec_t v;

        //           we  f3    a              wd            init          err rd            fin           lat nwr
        tbl[0]  = '{1'b0, 3'b000, 32'h4,        32'h0,        32'h8000_80F0, 1'b0, 32'hFFFF_FFF0, 32'h8000_80F0, 2, 0};
        tbl[1]  = '{1'b0, 3'b100, 32'h5,        32'h0,        32'h8000_80F0, 1'b0, 32'h0000_0080, 32'h8000_80F0, 2, 0};
        tbl[2]  = '{1'b0, 3'b001, 32'h6,        32'h0,        32'h8000_80F0, 1'b0, 32'hFFFF_8000, 32'h8000_80F0, 2, 0};
        tbl[3]  = '{1'b0, 3'b101, 32'h6,        32'h0,        32'h8000_80F0, 1'b0, 32'h0000_8000, 32'h8000_80F0, 2, 0};
        tbl[4]  = '{1'b1, 3'b000, 32'hB,        32'hAA,       32'h1122_3344, 1'b0, 32'h0,         32'hAA22_3344, 3, 1};
        tbl[5]  = '{1'b1, 3'b001, 32'hA,        32'hBEEF,     32'h1122_3344, 1'b0, 32'h0,         32'hBEEF_3344, 3, 1};
        tbl[6]  = '{1'b0, 3'b010, 32'h6,        32'h0,        32'h1122_3344, 1'b1, 32'h0,         32'h1122_3344, 1, 0};
        tbl[7]  = '{1'b1, 3'b001, 32'h3,        32'hBEEF,     32'h1122_3344, 1'b1, 32'h0,         32'h1122_3344, 1, 0};
        tbl[8]  = '{1'b0, 3'b011, 32'h8,        32'h0,        32'h1122_3344, 1'b1, 32'h0,         32'h1122_3344, 1, 0};
        tbl[9]  = '{1'b1, 3'b100, 32'h8,        32'h5555_5555, 32'h1122_3344, 1'b1, 32'h0,        32'h1122_3344, 1, 0};
        tbl[10] = '{1'b1, 3'b010, 32'h8,        32'hDEAD_BEEF, 32'h1122_3344, 1'b0, 32'h0,        32'hDEAD_BEEF, 2, 1};
        tbl[11] = '{1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,       32'h1234_5678, 1'b0, 32'h1234_5678, 32'h1234_5678, 2, 0};
        tbl[12] = '{1'b1, 3'b000, 32'h3,        32'h55,       32'h0,         1'b0, 32'h0,         32'h5500_0000, 3, 1};

        rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", {26'd0, resp_valid, resp_err, MemRW, 3'd0}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_dataw", dataW, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run($sformatf("vec%0d", i), tbl[i]);

        // Reset during WRITE: strobe drops at once, nothing commits, no response.
        preload(32'hC, 32'h1111_1111);
        w0 = wr_cnt;
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'hC; req_wdata = 32'h2222_2222;
        @(posedge clk); @(negedge clk);
        req_valid = 0;
        chk("rstw_in_write", 32'(MemRW), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_memrw", 32'(MemRW), 32'd0);
        chk("rstw_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rstw_nwr", wr_cnt - w0, 0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("rstw_noresp", 32'(resp_valid), 32'd0);
        run("rstw_reload", model(1'b0, 3'b010, 32'hC, 32'h0, 32'h1111_1111));

        // Back-to-back loads with req_valid held high.
        preload(32'h10, 32'hCAFE_F00D);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10;
        for (int c = 0; c < 16; c++) begin
            if (req_ready) acc.push_back(c);
            if (resp_valid) rsp.push_back(c);
            @(negedge clk);
        end
        req_valid = 0;
        chk("b2b_acc_cnt", acc.size(), 6);
        for (int i = 1; i < acc.size(); i++) chk($sformatf("b2b_acc_gap%0d", i), acc[i] - acc[i-1], 3);
        for (int i = 1; i < rsp.size(); i++) chk($sformatf("b2b_rsp_gap%0d", i), rsp[i] - rsp[i-1], 3);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("b2b_drain", 32'(ok), 32'd1);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a  = $urandom;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            v = model(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom);
            run($sformatf("rnd%0d", i), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
